uart_rx_data_sampler: RTL and testbench

- Oversampling front end of the UART receiver. Runs the per-bit edge counter and takes three mid-bit samples of the serial line, then resolves them by majority vote.
- Delivers one resolved bit per bit period as a sample plus a one-cycle valid strobe.
- Downstream consumers are the start/parity/stop checkers and the deserializer. The RX FSM drives the enable and uses the bit-boundary tick to advance its state.

---
 rtl/uart_rx_data_sampler.sv | 118 +++++++++++
 tb/tb_uart_rx_data_sampler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_data_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_data_sampler
//  Purpose  : Oversampling front end of the UART receiver. Counts edges
//             within each bit period, captures the serial line at three
//             mid-bit points and resolves them by majority vote into one
//             sample per bit, flagged by a one-cycle valid strobe.
//  Ports    :
//    DatSmp_CLK          in   oversampling clock
//    DatSmp_RST          in   synchronous active-low reset
//    DatSmp_RX_IN        in   serial line (idle high, pre-synchronised)
//    DatSmp_Prescale     in   oversampling ratio (8/16/32, else treated as 8)
//    DatSmp_dat_samp_en  in   sampling enable from the RX FSM
//    DatSmp_edge_cnt     out  edge count within the current bit, 0..P-1
//    DatSmp_bit_tick     out  pulse on the last edge of each bit period
//    DatSmp_sample       out  majority-voted bit
//    DatSmp_Sample_Valid out  one-cycle strobe qualifying DatSmp_sample
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_data_sampler #(
    parameter int CNT_W = 6
) (
    input  logic             DatSmp_CLK,
    input  logic             DatSmp_RST,
    input  logic             DatSmp_RX_IN,
    input  logic [CNT_W-1:0] DatSmp_Prescale,
    input  logic             DatSmp_dat_samp_en,
    output logic [CNT_W-1:0] DatSmp_edge_cnt,
    output logic             DatSmp_bit_tick,
    output logic             DatSmp_sample,
    output logic             DatSmp_Sample_Valid
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_p8  = CNT_W'(8);
    localparam logic [CNT_W-1:0] c_p16 = CNT_W'(16);
    localparam logic [CNT_W-1:0] c_p32 = CNT_W'(32);

    logic [CNT_W-1:0] r_prescale;
    logic [CNT_W-1:0] r_edgeCnt;
    logic             r_enPrev;
    logic             r_s0;
    logic             r_s1;
    logic             r_sample;
    logic             r_sampleValid;

    logic [CNT_W-1:0] w_decodedP;
    logic [CNT_W-1:0] w_effP;
    logic [CNT_W-1:0] w_lastCnt;
    logic [CNT_W-1:0] w_half;
    logic             w_firstEn;
    logic             w_vote;

    // Unsupported ratios fall back to the smallest legal one.
    always_comb begin
        w_decodedP = c_p8;
        case (DatSmp_Prescale)
            c_p16:   w_decodedP = c_p16;
            c_p32:   w_decodedP = c_p32;
            default: w_decodedP = c_p8;
        endcase
    end

    // In the first enabled cycle the latch has not been written yet, so the
    // freshly decoded ratio is used directly for that cycle's comparisons.
    assign w_firstEn = DatSmp_dat_samp_en & ~r_enPrev;
    assign w_effP    = w_firstEn ? w_decodedP : r_prescale;
    assign w_lastCnt = w_effP - c_one;
    assign w_half    = w_effP >> 1;

    // The third sample point is the live line value, not a stored copy.
    assign w_vote = (r_s0 & r_s1) | (r_s0 & DatSmp_RX_IN) | (r_s1 & DatSmp_RX_IN);

    always_ff @(posedge DatSmp_CLK) begin
        if (!DatSmp_RST) begin
            r_prescale    <= '0;
            r_edgeCnt     <= '0;
            r_enPrev      <= 1'b0;
            r_s0          <= 1'b0;
            r_s1          <= 1'b0;
            r_sample      <= 1'b0;
            r_sampleValid <= 1'b0;
        end else begin
            r_enPrev <= DatSmp_dat_samp_en;
            if (w_firstEn) begin
                r_prescale <= w_decodedP;
            end
            if (!DatSmp_dat_samp_en) begin
                // Disabling abandons any partial vote and clears the result.
                r_edgeCnt     <= '0;
                r_s0          <= 1'b0;
                r_s1          <= 1'b0;
                r_sample      <= 1'b0;
                r_sampleValid <= 1'b0;
            end else begin
                r_edgeCnt     <= (r_edgeCnt == w_lastCnt) ? '0 : r_edgeCnt + c_one;
                r_sampleValid <= 1'b0;
                if (r_edgeCnt == w_half - c_one) begin
                    r_s0 <= DatSmp_RX_IN;
                end
                if (r_edgeCnt == w_half) begin
                    r_s1 <= DatSmp_RX_IN;
                end
                if (r_edgeCnt == w_half + c_one) begin
                    r_sample      <= w_vote;
                    r_sampleValid <= 1'b1;
                end
            end
        end
    end

    assign DatSmp_edge_cnt     = r_edgeCnt;
    assign DatSmp_bit_tick     = DatSmp_dat_samp_en & (r_edgeCnt == w_lastCnt);
    assign DatSmp_sample       = r_sample;
    assign DatSmp_Sample_Valid = r_sampleValid;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_data_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_data_sampler
//  Purpose  : Self-checking bench for uart_rx_data_sampler. A run-based model
//             (enabled-cycle index within the current enable run, modulo P,
//             plus a history of line values) is compared against the DUT on
//             every cycle; directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_data_sampler;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       en;
    logic [5:0] edgeCnt;
    logic       bitTick;
    logic       sample;
    logic       sampleValid;

    int checks = 0;
    int errors = 0;

    uart_rx_data_sampler #(.CNT_W(6)) dut (
        .DatSmp_CLK          (clk),
        .DatSmp_RST          (rst),
        .DatSmp_RX_IN        (rx),
        .DatSmp_Prescale     (prescale),
        .DatSmp_dat_samp_en  (en),
        .DatSmp_edge_cnt     (edgeCnt),
        .DatSmp_bit_tick     (bitTick),
        .DatSmp_sample       (sample),
        .DatSmp_Sample_Valid (sampleValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decP(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    // ---------------- behavioural model ----------------
    // k  : enabled cycles elapsed in the current enable run before this cycle
    // mP : ratio latched at the start of the run
    // hist: line value seen in each enabled cycle of the run
    bit modelOn = 0;
    int k = 0;
    int mP = 0;
    bit mSample = 0;
    bit hist[$];
    int pCur, expCnt;
    bit expTick, expValid;

    always @(negedge clk) begin
        pCur = (en && k == 0) ? decP(int'(prescale)) : mP;
        expCnt = (k == 0) ? 0 : k % mP;
        expTick = 1'b0;
        if (en) expTick = ((k % pCur) == pCur - 1);
        expValid = 1'b0;
        if (k >= 1) expValid = ((k % mP) == mP / 2 + 2);
        if (modelOn) begin
            checks++;
            if ({edgeCnt, bitTick, sample, sampleValid} !==
                {6'(expCnt), expTick, mSample, expValid}) begin
                errors++;
                $display("FAIL model: cnt/tick/smp/vld got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b at %0t",
                         edgeCnt, bitTick, sample, sampleValid,
                         expCnt, expTick, mSample, expValid, $time);
            end
        end
        // advance to the state after the coming clock edge
        if (!rst) begin
            k = 0; mP = 0; mSample = 1'b0; hist.delete();
        end else if (en) begin
            if (k == 0) begin
                mP = pCur;
                hist.delete();
            end
            hist.push_back(rx);
            if ((k % mP) == mP / 2 + 1)
                mSample = (hist[k-2] & hist[k-1]) | (hist[k-2] & hist[k]) | (hist[k-1] & hist[k]);
            k++;
        end else begin
            k = 0;
            mSample = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] oCnt;
    logic       oTick, oSample, oValid;

    task automatic step(input bit e, input bit r);
        en = e;
        rx = r;
        @(negedge clk);
        oCnt = edgeCnt; oTick = bitTick; oSample = sample; oValid = sampleValid;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    bit frameBits[10];
    bit got[$];
    int ticks;
    bit r;

    initial begin
        rst = 1'b0; en = 1'b0; rx = 1'b1; prescale = 6'd16;
        step(1'b0, 1'b1);
        modelOn = 1'b1;
        step(1'b0, 1'b1);
        chk("reset_cnt", int'(oCnt), 0);
        chk("reset_smp", int'(oSample), 0);
        chk("reset_vld", int'(oValid), 0);
        rst = 1'b1;
        idle(2);

        // nominal timing, P=8
        prescale = 6'd8;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            chk("nom_cnt", int'(oCnt), i % 8);
            chk("nom_tick", int'(oTick), (i == 7 || i == 15) ? 1 : 0);
            chk("nom_vld", int'(oValid), (i == 6 || i == 14) ? 1 : 0);
            if (i == 6 || i == 14) chk("nom_smp", int'(oSample), 0);
        end
        idle(2);

        // majority vote, P=16, three consecutive bits
        prescale = 6'd16;
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 16; j++) begin
                case (b)
                    0: r = (j == 7) ? 1'b0 : 1'b1;
                    1: r = (j == 9) ? 1'b1 : 1'b0;
                    default: r = (j == 7 || j == 8) ? 1'b1 : 1'b0;
                endcase
                step(1'b1, r);
                if (j == 10) begin
                    chk("maj_vld", int'(oValid), 1);
                    chk("maj_smp", int'(oSample), (b == 1) ? 0 : 1);
                end
            end
        end
        idle(2);

        // prescale latched at 32, later change ignored
        prescale = 6'd32;
        for (int i = 0; i < 64; i++) begin
            if (i == 5) prescale = 6'd8;
            step(1'b1, 1'b1);
            if (i == 31) begin
                chk("p32_cnt31", int'(oCnt), 31);
                chk("p32_tick", int'(oTick), 1);
            end
            if (i == 32) chk("p32_wrap", int'(oCnt), 0);
            if (i == 10) chk("p32_novld", int'(oValid), 0);
            if (i == 18 || i == 50) begin
                chk("p32_vld", int'(oValid), 1);
                chk("p32_smp", int'(oSample), 1);
            end
        end
        idle(2);

        // illegal ratio behaves as 8
        prescale = 6'd12;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            if (i == 7) chk("p12_cnt7", int'(oCnt), 7);
            if (i == 8) chk("p12_wrap", int'(oCnt), 0);
            if (i == 6) chk("p12_vld", int'(oValid), 1);
        end
        idle(2);

        // enable drop at the vote point of the second bit
        prescale = 6'd16;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1);
            if (i == 10) chk("drop_vld0", int'(oValid), 1);
            if (i == 21) chk("drop_hold", int'(oSample), 1);
        end
        step(1'b0, 1'b1);
        chk("drop_tick", int'(oTick), 0);
        step(1'b0, 1'b1);
        chk("drop_cnt", int'(oCnt), 0);
        chk("drop_novld", int'(oValid), 0);
        chk("drop_smp", int'(oSample), 0);
        step(1'b1, 1'b1);
        chk("drop_reen", int'(oCnt), 0);
        idle(2);

        // reset mid-operation with enable held high
        for (int i = 0; i < 25; i++) step(1'b1, 1'b1);
        chk("rstm_pre", int'(oSample), 1);
        rst = 1'b0;
        step(1'b1, 1'b1);
        chk("rstm_cnt9", int'(oCnt), 9);
        rst = 1'b1;
        step(1'b1, 1'b1);
        chk("rstm_cnt", int'(oCnt), 0);
        chk("rstm_tick", int'(oTick), 0);
        chk("rstm_smp", int'(oSample), 0);
        chk("rstm_vld", int'(oValid), 0);
        step(1'b1, 1'b1);
        chk("rstm_cnt1", int'(oCnt), 1);
        step(1'b1, 1'b1);
        chk("rstm_cnt2", int'(oCnt), 2);
        idle(2);

        // full frame 0xA5 with a glitch on one sample point of bit 3
        frameBits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        got.delete();
        ticks = 0;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 16; j++) begin
                r = frameBits[b];
                if (b == 3 && j == 8) r = ~r;
                step(1'b1, r);
                if (oValid) got.push_back(oSample);
                if (oTick) ticks++;
            end
        end
        idle(2);
        chk("frm_nvld", got.size(), 10);
        chk("frm_ticks", ticks, 10);
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) chk("frm_bit", int'(got[i]), int'(frameBits[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
